// File: rtl/nth_root_stream.sv
// Streaming unsigned fixed-point n-th root: MSB-first guessing, with one truncating multiply per cycle
// used to raise each candidate to the n-th power. Valid/ready handshakes on both sides.
module nth_root_stream #(
    parameter int IN_W   = 10,
    parameter int FRAC_W = 10,
    parameter int EXP_W  = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_W-1:0]         in_x,
    input  logic [EXP_W-1:0]        in_n,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IN_W+FRAC_W-1:0]  out_data,
    output logic                    out_exact,
    output logic                    out_err
);
    localparam int OUT_W     = IN_W + FRAC_W;
    localparam int START_BIT = FRAC_W + (IN_W + 1) / 2 - 1;
    localparam int NBITS     = START_BIT + 1;
    localparam int BIT_W     = $clog2(NBITS);
    localparam int PROD_W    = 2 * OUT_W;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_POW, S_CMP, S_DONE} state_t;

    state_t             state_q, state_n;
    logic [IN_W-1:0]    x_q, x_n;
    logic [EXP_W-1:0]   n_q, n_n, k_q, k_n;
    logic [OUT_W-1:0]   acc_q, acc_n, cand_q, cand_n, pow_q, pow_n;
    logic [BIT_W-1:0]   bit_q, bit_n;
    logic               abort_q, abort_n, exact_q, exact_n, err_q, err_n;

    logic [OUT_W-1:0]   x_full;
    logic [PROD_W-1:0]  prod, pow_next;
    logic [OUT_W-1:0]   acc_keep;
    logic [BIT_W-1:0]   bit_dec;
    logic               keep;

    // Radicand scaled into the result's Q format so candidate powers compare directly.
    assign x_full   = {x_q, {FRAC_W{1'b0}}};
    assign prod     = PROD_W'(pow_q) * PROD_W'(cand_q);
    assign pow_next = prod >> FRAC_W;
    assign keep     = !abort_q && (pow_q <= x_full);
    assign acc_keep = keep ? cand_q : acc_q;
    assign bit_dec  = bit_q - BIT_W'(1);

    always_comb begin
        // NOTE: every next-state variable gets a default first so no path infers a latch.
        state_n = state_q;
        x_n     = x_q;
        n_n     = n_q;
        k_n     = k_q;
        acc_n   = acc_q;
        cand_n  = cand_q;
        pow_n   = pow_q;
        bit_n   = bit_q;
        abort_n = abort_q;
        exact_n = exact_q;
        err_n   = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_n     = in_x;
                    n_n     = in_n;
                    state_n = S_SETUP;
                end
            end
            S_SETUP: begin
                acc_n   = '0;
                bit_n   = BIT_W'(START_BIT);
                abort_n = 1'b0;
                exact_n = 1'b0;
                err_n   = 1'b0;
                if (n_q == '0) begin
                    err_n   = 1'b1;
                    state_n = S_DONE;
                end else if (n_q == EXP_W'(1)) begin
                    acc_n   = x_full;
                    exact_n = 1'b1;
                    state_n = S_DONE;
                end else if (x_q == '0) begin
                    exact_n = 1'b1;
                    state_n = S_DONE;
                end else begin
                    cand_n  = OUT_W'(1) << START_BIT;
                    pow_n   = OUT_W'(1) << START_BIT;
                    k_n     = EXP_W'(1);
                    state_n = S_POW;
                end
            end
            S_POW: begin
                k_n = k_q + EXP_W'(1);
                // Powers only grow once they pass X, so an overshoot settles the candidate.
                if (pow_next > PROD_W'(x_full)) begin
                    abort_n = 1'b1;
                    state_n = S_CMP;
                end else begin
                    pow_n = pow_next[OUT_W-1:0];
                    if (k_q + EXP_W'(1) == n_q) state_n = S_CMP;
                end
            end
            S_CMP: begin
                acc_n = acc_keep;
                if (keep && (pow_q == x_full)) begin
                    exact_n = 1'b1;
                    state_n = S_DONE;
                end else if (bit_q == '0) begin
                    state_n = S_DONE;
                end else begin
                    bit_n   = bit_dec;
                    cand_n  = acc_keep | (OUT_W'(1) << bit_dec);
                    pow_n   = acc_keep | (OUT_W'(1) << bit_dec);
                    k_n     = EXP_W'(1);
                    abort_n = 1'b0;
                    state_n = S_POW;
                end
            end
            S_DONE: begin
                if (out_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            n_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            cand_q  <= '0;
            pow_q   <= '0;
            bit_q   <= '0;
            abort_q <= 1'b0;
            exact_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            x_q     <= x_n;
            n_q     <= n_n;
            k_q     <= k_n;
            acc_q   <= acc_n;
            cand_q  <= cand_n;
            pow_q   <= pow_n;
            bit_q   <= bit_n;
            abort_q <= abort_n;
            exact_q <= exact_n;
            err_q   <= err_n;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_data  = out_valid ? acc_q : '0;
    assign out_exact = out_valid && exact_q;
    assign out_err   = out_valid && err_q;

endmodule

// File: tb/tb_nth_root_stream.sv
// Scoreboard bench for nth_root_stream: a bit-exact reference model predicts result, flags and
// latency at acceptance; predictions are popped and compared when the result handshake occurs.
module tb_nth_root_stream;
    localparam int IN_W   = 10;
    localparam int FRAC_W = 10;
    localparam int EXP_W  = 3;
    localparam int OUT_W  = IN_W + FRAC_W;
    localparam int START_BIT = FRAC_W + (IN_W + 1) / 2 - 1;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic             exact;
        logic             err;
        int               lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_x;
    logic [EXP_W-1:0] in_n;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_exact;
    logic             out_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    nth_root_stream #(.IN_W(IN_W), .FRAC_W(FRAC_W), .EXP_W(EXP_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_n(in_n),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_exact(out_exact), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Greedy MSB-first reference, counting SETUP, each multiply, each compare and the first DONE cycle.
    function automatic exp_t model(input int x, input int n);
        exp_t   e;
        longint xf, acc, c, p;
        bit     ab, fin;
        xf = longint'(x) << FRAC_W;
        e.data = '0; e.exact = 1'b0; e.err = 1'b0; e.lat = 2;
        if (n == 0) begin
            e.err = 1'b1;
        end else if (n == 1) begin
            e.data = OUT_W'(xf); e.exact = 1'b1;
        end else if (x == 0) begin
            e.exact = 1'b1;
        end else begin
            acc = 0; e.lat = 1; fin = 1'b0;
            for (int b = START_BIT; b >= 0 && !fin; b--) begin
                c = acc | (longint'(1) << b);
                p = c; ab = 1'b0;
                for (int k = 2; k <= n && !ab; k++) begin
                    p = (p * c) >> FRAC_W;
                    e.lat++;
                    if (p > xf) ab = 1'b1;
                end
                e.lat++;
                if (!ab && p <= xf) begin
                    acc = c;
                    if (p == xf) begin e.exact = 1'b1; fin = 1'b1; end
                end
            end
            e.lat++;
            e.data = OUT_W'(acc);
        end
        return e;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_out_data"}, 64'(out_data), 64'(0));
        check({tag, "_out_exact"}, 64'(out_exact), 64'(0));
        check({tag, "_out_err"}, 64'(out_err), 64'(0));
    endtask

    // Drive one operand, keep junk on in_valid while busy, then check and consume the result.
    task automatic do_op(input int x, input int n, input int hold, input bit want_lat);
        exp_t e;
        int   lat;
        int   guard;
        @(negedge clk);
        in_x = IN_W'(x); in_n = EXP_W'(n); in_valid = 1'b1; out_ready = 1'b0;
        guard = 0;
        while (!in_ready && guard < 200) begin @(negedge clk); guard++; end
        if (!in_ready) begin
            check("accept_timeout", 64'(0), 64'(1));
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb.push_back(model(x, n));
        @(negedge clk);
        in_x = IN_W'($urandom); in_n = EXP_W'($urandom); lat = 1;
        while (!out_valid && lat < 300) begin @(negedge clk); lat++; end
        e = sb.pop_front();
        if (!out_valid) begin
            check($sformatf("result_timeout_x%0d_n%0d", x, n), 64'(0), 64'(1));
            in_valid = 1'b0;
            return;
        end
        check($sformatf("data_x%0d_n%0d", x, n), 64'(out_data), 64'(e.data));
        check($sformatf("exact_x%0d_n%0d", x, n), 64'(out_exact), 64'(e.exact));
        check($sformatf("err_x%0d_n%0d", x, n), 64'(out_err), 64'(e.err));
        check($sformatf("busy_x%0d_n%0d", x, n), 64'(in_ready), 64'(0));
        if (want_lat) check($sformatf("lat_x%0d_n%0d", x, n), 64'(lat), 64'(e.lat));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check($sformatf("hold%0d_valid", i), 64'(out_valid), 64'(1));
            check($sformatf("hold%0d_data", i), 64'(out_data), 64'(e.data));
            check($sformatf("hold%0d_flags", i), 64'({out_exact, out_err, in_ready}),
                  64'({e.exact, e.err, 1'b0}));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;
        check($sformatf("consumed_valid_x%0d_n%0d", x, n), 64'(out_valid), 64'(0));
        check($sformatf("consumed_ready_x%0d_n%0d", x, n), 64'(in_ready), 64'(1));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_x = '0; in_n = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;

        do_op(16, 2, 0, 1'b1);
        do_op(2, 2, 0, 1'b1);
        check("lat_x2_n2_spec", 64'(model(2, 2).lat), 64'(32));
        do_op(8, 3, 0, 1'b1);
        do_op(1023, 7, 0, 1'b1);
        do_op(5, 1, 0, 1'b1);
        do_op(9, 0, 0, 1'b1);
        do_op(0, 5, 0, 1'b1);
        do_op(1023, 2, 0, 1'b1);
        do_op(1, 7, 0, 1'b1);
        do_op(700, 3, 10, 1'b1);

        for (int i = 0; i < 60; i++)
            do_op(int'($urandom_range(0, 1023)), int'($urandom_range(2, 7)), int'($urandom_range(0, 2)), 1'b1);

        // Synchronous reset while the power loop is running.
        @(negedge clk);
        in_x = IN_W'(1000); in_n = EXP_W'(4); in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle("midop_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_no_valid", 64'(out_valid), 64'(0));
        do_op(81, 4, 0, 1'b1);
        check("x81_n4_model", 64'(model(81, 4).data), 64'(20'h00C00));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end
endmodule

// File: doc/nth_root_stream.md
Name: nth_root_stream

Overview:
- Computes the unsigned fixed-point n-th root y of an integer x, for a runtime exponent n.
- Method: MSB-first bit-by-bit guessing. Each candidate is raised to the n-th power by repeated truncating multiplication, one multiply per cycle.
- Sits in the arithmetic datapath beside the existing divide and root units. Uses valid/ready handshakes on both input and output so it can be chained and back-pressured.
- Also reports illegal exponents and terminates early on exact or trivial cases.

Parameters:
- IN_W, 10: integer input width (bits of x).
- FRAC_W, 10: fractional bits of the result.
- EXP_W, 3: exponent width; n ranges 0..2^EXP_W-1.
- Derived: OUT_W = IN_W+FRAC_W; START_BIT = FRAC_W+ceil(IN_W/2)-1 (first candidate bit); NBITS = START_BIT+1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- in_valid  in  1  operand valid
- in_ready  out  1  block can accept an operand
- in_x  in  IN_W  radicand x, unsigned integer
- in_n  in  EXP_W  exponent n
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  OUT_W  root, unsigned Q(IN_W).(FRAC_W)
- out_exact  out  1  out_data^n (truncated) equals x exactly
- out_err  out  1  n==0 (illegal exponent)

Behaviour:
- Reset (already decided): reset rst_n, synchronous, active-low; clock clk.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_exact=0, out_err=0, FSM=IDLE.
- Reset mid-operation: abandons the operation and returns to IDLE. No stale out_valid afterwards.
- Acceptance: the operand is accepted on an edge with in_valid&&in_ready. x and n are latched internally; inputs are ignored until the next acceptance. in_ready=1 only in IDLE.
- Arithmetic:
  - X = x<<FRAC_W (OUT_W bits).
  - Power sequence for candidate c: p1=c; pk=floor(p(k-1)*c / 2^FRAC_W). Products are 2*OUT_W bits wide with no truncation before the shift.
  - If any pk > X, the power loop aborts at once and c is rejected.
  - Result = greedy MSB-first: acc starts at 0. For bit b from START_BIT down to 0, c = acc|(1<<b); keep c if pn <= X.
  - Truncated pn is monotonic in c, so the result is the largest y with truncated y^n <= X.
- FSM states:
  - IDLE: on acceptance, go to SETUP.
  - SETUP (1 cycle): latch X and set acc=0, bit=START_BIT. If n==0: err=1, result 0, go to DONE. If n==1: result X, exact=1, go to DONE. If x==0: result 0, exact=1, go to DONE. Otherwise load p=c, k=1, go to POW (or straight to CMP when n==1 is excluded, so POW always runs at least once).
  - POW: one multiply per cycle, k increments. Go to CMP when k reaches n or on abort.
  - CMP (1 cycle): if p<=X and no abort, acc=c.
    - If p==X: exact=1, go to DONE (early exit).
    - Else if bit==0: go to DONE.
    - Else bit-=1, load the next candidate, go to POW.
  - DONE: out_valid=1 with out_data=acc, out_exact, out_err held stable. On out_valid&&out_ready, out_valid drops next cycle and the FSM returns to IDLE; in_ready=1 in that following cycle.
- Latency (acceptance edge to first out_valid cycle):
  - n in {0,1}, or x==0: exactly 2 cycles.
  - Otherwise at most 2+NBITS*n cycles; less on abort or exact match.
- Back-pressure: with out_ready low, out_valid and all result fields hold indefinitely.
- Simultaneous events: in_valid is ignored outside IDLE. No operand is accepted in the same cycle a result is consumed.

Test Plan:
- Defaults, x=16, n=2 -> out_data=0x01000 (4.0), out_exact=1, out_err=0; early exit, so latency < 2+15*2.
- x=2, n=2 -> out_data=0x005A8 (1448: 1448^2>>10=2047<=2048, 1449 gives 2050), out_exact=0, latency exactly 2+15*2=32.
- x=8, n=3 -> 0x00800 with out_exact=1.
- x=1023, n=7 -> result matches the bit-exact reference model.
- Random sweep over all x and n=2..7 against the model.
- x=5, n=1 -> 0x01400, exact=1, latency 2.
- x=9, n=0 -> out_err=1, out_data=0, latency 2.
- x=0, n=5 -> 0, exact=1.
- Hold out_ready=0 for 10 cycles after out_valid -> outputs stable and in_ready=0. Then out_ready=1 -> out_valid low next cycle and in_ready high.
- Assert rst_n=0 for 1 cycle mid-POW (x=1000, n=4) -> all outputs at reset values next cycle. A new operand x=81, n=4 then yields 0x00C00, exact=1.
